// File: rtl/pi_integral_if.sv
// Handshake/data bundle between the error stage and the PI integral unit.
// Master drives the request and operands; slave returns the integral term and status.
interface pi_integral_if #(
    parameter int EW = 9,
    parameter int KW = 5,
    parameter int IW = 17
);
    logic                 compute;
    logic                 clear;
    logic signed [EW-1:0] ek;
    logic        [KW-1:0] ki;
    logic signed [IW-1:0] ik;
    logic                 busy;
    logic                 done;
    logic                 sat;

    modport master (
        output compute, clear, ek, ki,
        input  ik, busy, done, sat
    );

    modport slave (
        input  compute, clear, ek, ki,
        output ik, busy, done, sat
    );
endinterface

// File: rtl/pi_integral_unit.sv
// PI integral term: ik += ek*ki via KW-cycle shift-add, result after KW+1 cycles; compute ignored while busy.
// Optional clamp to [IMIN, IMAX] when PI_INTEGRAL_SAT_EN is defined, otherwise two's-complement wrap.
module pi_integral_unit #(
    parameter int EW   = 9,
    parameter int KW   = 5,
    parameter int IW   = 17,
    parameter int IMAX = 65535,
    parameter int IMIN = -65536
) (
    input  logic       clk,
    input  logic       rst,
    pi_integral_if.slave bus
);
    localparam int PW = EW + KW + 1;
    localparam int SW = ((IW > PW) ? IW : PW) + 1;
    localparam int CW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

    state_t               state;
    logic signed [EW-1:0] ek_q;
    logic        [KW-1:0] ki_q;
    logic signed [PW-1:0] prod;
    logic        [CW-1:0] cnt;
    logic signed [IW-1:0] ik_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 sat_q;

    logic signed [PW-1:0] addend;
    logic signed [SW-1:0] sum;
    logic signed [IW-1:0] ik_next;
    logic                 sat_next;

    localparam logic signed [SW-1:0] IMAX_W = SW'(IMAX);
    localparam logic signed [SW-1:0] IMIN_W = SW'(IMIN);

    // Sum is one bit wider than either operand so the add itself never overflows.
    always_comb begin
        addend = PW'(ek_q) <<< cnt;
        sum    = SW'(ik_q) + SW'(prod);
    end

`ifdef PI_INTEGRAL_SAT_EN
    always_comb begin
        ik_next  = sum[IW-1:0];
        sat_next = 1'b0;
        if (sum > IMAX_W) begin
            ik_next  = IMAX_W[IW-1:0];
            sat_next = 1'b1;
        end else if (sum < IMIN_W) begin
            ik_next  = IMIN_W[IW-1:0];
            sat_next = 1'b1;
        end
    end
`else
    // Wrap mode keeps the legacy truncation; limits and upper sum bits are don't-care.
    always_comb begin
        ik_next  = sum[IW-1:0];
        sat_next = 1'b0;
    end
    wire unused_lim = ^{IMAX_W, IMIN_W, sum[SW-1:IW]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ek_q   <= '0;
            ki_q   <= '0;
            prod   <= '0;
            cnt    <= '0;
            ik_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (bus.clear) begin
            state  <= IDLE;
            prod   <= '0;
            cnt    <= '0;
            ik_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.compute) begin
                        ek_q   <= bus.ek;
                        ki_q   <= bus.ki;
                        prod   <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    if (ki_q[cnt]) begin
                        prod <= prod + addend;
                    end
                    if (cnt == CW'(KW - 1)) begin
                        state <= ACC;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACC: begin
                    ik_q   <= ik_next;
                    sat_q  <= sat_next;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ik   = ik_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sat  = sat_q;
endmodule

// File: tb/tb_pi_integral_unit.sv
// Bench for pi_integral_unit: directed scenarios plus random operands against an arithmetic model.
// Honours PI_INTEGRAL_SAT_EN the same way as the design.
module tb_pi_integral_unit;
    localparam int  EW   = 9;
    localparam int  KW   = 5;
    localparam int  IW   = 17;
    localparam int  IMAX = 65535;
    localparam int  IMIN = -65536;
    localparam int  LAT  = KW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pi_integral_if #(.EW(EW), .KW(KW), .IW(IW)) bus ();

    pi_integral_unit #(.EW(EW), .KW(KW), .IW(IW), .IMAX(IMAX), .IMIN(IMIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     pass_cnt = 0;
    int     total    = 0;
    longint m_ik     = 0;
    bit     m_sat    = 1'b0;

    // Model: integral += ek*ki, then clamp or wrap to IW bits.
    function automatic void ref_step(input int e, input int k);
        longint s;
        s = m_ik + longint'(e) * longint'(k);
`ifdef PI_INTEGRAL_SAT_EN
        if (s > IMAX) begin
            m_ik = IMAX; m_sat = 1'b1;
        end else if (s < IMIN) begin
            m_ik = IMIN; m_sat = 1'b1;
        end else begin
            m_ik = s; m_sat = 1'b0;
        end
`else
        begin
            longint r;
            r = s & ((64'sd1 <<< IW) - 1);
            if (r >= (64'sd1 <<< (IW - 1))) r = r - (64'sd1 <<< IW);
            m_ik  = r;
            m_sat = 1'b0;
        end
`endif
    endfunction

    // Issue one compute and wait (bounded) for done; lat=-1 on timeout.
    task automatic do_op(input int e, input int k, output int lat, output bit busy_seen);
        @(negedge clk);
        bus.compute = 1'b1;
        bus.ek      = EW'(e);
        bus.ki      = KW'(k);
        @(posedge clk);
        @(negedge clk);
        bus.compute = 1'b0;
        busy_seen   = bus.busy;
        lat         = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.compute = 1'b0; bus.clear = 1'b0; bus.ek = '0; bus.ki = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_ik = 0; m_sat = 1'b0;
        total++; if (bus.ik !== '0)   $display("FAIL reset_ik got %0d want 0", bus.ik);     else pass_cnt++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else pass_cnt++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.done); else pass_cnt++;
        total++; if (bus.sat !== 1'b0)  $display("FAIL reset_sat got %0b want 0", bus.sat);   else pass_cnt++;
    endtask

    task automatic test_basic();
        int e_t[3] = '{10, -20, -256};
        int k_t[3] = '{14, 14, 31};
        longint fixed_t[3] = '{140, -140, -8076};
        int lat; bit bsy;
        for (int i = 0; i < 3; i++) begin
            do_op(e_t[i], k_t[i], lat, bsy);
            ref_step(e_t[i], k_t[i]);
            total++; if (bsy !== 1'b1) $display("FAIL basic_busy[%0d] got %0b want 1", i, bsy); else pass_cnt++;
            total++; if (lat != LAT) $display("FAIL basic_latency[%0d] got %0d want %0d", i, lat, LAT); else pass_cnt++;
            total++; if (longint'(bus.ik) !== m_ik) $display("FAIL basic_ik[%0d] got %0d want %0d", i, bus.ik, m_ik); else pass_cnt++;
            total++; if (longint'(bus.ik) !== fixed_t[i]) $display("FAIL basic_ik_const[%0d] got %0d want %0d", i, bus.ik, fixed_t[i]); else pass_cnt++;
            total++; if (bus.sat !== m_sat) $display("FAIL basic_sat[%0d] got %0b want %0b", i, bus.sat, m_sat); else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        int lat; bit bsy;
        longint want9;
        bit     sat9;
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        m_ik = 0; m_sat = 1'b0;
        total++; if (bus.ik !== '0) $display("FAIL idle_clear_ik got %0d want 0", bus.ik); else pass_cnt++;
        total++; if (bus.done !== 1'b0) $display("FAIL idle_clear_done got %0b want 0", bus.done); else pass_cnt++;
        for (int i = 0; i < 9; i++) begin
            do_op(255, 31, lat, bsy);
            ref_step(255, 31);
        end
`ifdef PI_INTEGRAL_SAT_EN
        want9 = 65535; sat9 = 1'b1;
`else
        want9 = -59927; sat9 = 1'b0;
`endif
        total++; if (longint'(bus.ik) !== want9) $display("FAIL sat_ik9 got %0d want %0d", bus.ik, want9); else pass_cnt++;
        total++; if (bus.sat !== sat9) $display("FAIL sat_flag9 got %0b want %0b", bus.sat, sat9); else pass_cnt++;
        total++; if (longint'(bus.ik) !== m_ik) $display("FAIL sat_model9 got %0d want %0d", bus.ik, m_ik); else pass_cnt++;
        do_op(-1, 31, lat, bsy);
        ref_step(-1, 31);
        total++; if (longint'(bus.ik) !== m_ik) $display("FAIL sat_release_ik got %0d want %0d", bus.ik, m_ik); else pass_cnt++;
        total++; if (bus.sat !== 1'b0) $display("FAIL sat_release_flag got %0b want 0", bus.sat); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int  dones = 0;
        bit  prev  = 1'b0;
        bit  consec = 1'b0;
        int  starts;
        @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        m_ik = 0; m_sat = 1'b0;
        bus.compute = 1'b1; bus.ek = EW'(1); bus.ki = KW'(1);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 19) bus.compute = 1'b0;
            if (bus.done) dones++;
            if (bus.done && prev) consec = 1'b1;
            prev = bus.done;
        end
        // Starts happen every KW+2 cycles within the 20-cycle request window.
        starts = (20 + KW + 1) / (KW + 2);
        for (int i = 0; i < starts; i++) ref_step(1, 1);
        total++; if (dones != starts) $display("FAIL b2b_done_count got %0d want %0d", dones, starts); else pass_cnt++;
        total++; if (consec !== 1'b0) $display("FAIL b2b_done_consecutive got %0b want 0", consec); else pass_cnt++;
        total++; if (longint'(bus.ik) !== m_ik) $display("FAIL b2b_ik got %0d want %0d", bus.ik, m_ik); else pass_cnt++;
    endtask

    task automatic test_clear_abort();
        int lat; bit bsy;
        bit saw_done = 1'b0;
        do_op(5, 3, lat, bsy);
        ref_step(5, 3);
        @(negedge clk);
        bus.compute = 1'b1; bus.ek = EW'(100); bus.ki = KW'(5);
        @(posedge clk);
        @(negedge clk);
        bus.compute = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        bus.clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clear = 1'b0;
        m_ik = 0; m_sat = 1'b0;
        total++; if (bus.ik !== '0) $display("FAIL abort_ik got %0d want 0", bus.ik); else pass_cnt++;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %0b want 0", bus.busy); else pass_cnt++;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL abort_done got %0b want 0", saw_done); else pass_cnt++;

        do_op(3, 2, lat, bsy);
        ref_step(3, 2);
        @(negedge clk);
        bus.compute = 1'b1; bus.ek = EW'(100); bus.ki = KW'(5);
        @(posedge clk);
        @(negedge clk);
        bus.compute = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ik = 0; m_sat = 1'b0;
        total++; if ({bus.ik, bus.busy, bus.done, bus.sat} !== '0)
            $display("FAIL midrst_outputs got ik=%0d busy=%0b done=%0b sat=%0b want all 0", bus.ik, bus.busy, bus.done, bus.sat);
        else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_operand_latch();
        longint prev;
        int     lat = -1;
        prev = m_ik;
        @(negedge clk);
        bus.compute = 1'b1; bus.ek = EW'(7); bus.ki = KW'(3);
        @(posedge clk);
        @(negedge clk);
        bus.compute = 1'b0;
        bus.ek = EW'(-50); bus.ki = KW'(31);
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        ref_step(7, 3);
        total++; if (lat != LAT) $display("FAIL latch_latency got %0d want %0d", lat, LAT); else pass_cnt++;
        total++; if (longint'(bus.ik) !== prev + 21) $display("FAIL latch_ik got %0d want %0d", bus.ik, prev + 21); else pass_cnt++;
    endtask

    task automatic test_random();
        int e, k, lat;
        bit bsy;
        for (int i = 0; i < 30; i++) begin
            e = int'($urandom_range(0, 511)) - 256;
            k = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
            do_op(e, k, lat, bsy);
            ref_step(e, k);
            total++; if (lat != LAT) $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, LAT); else pass_cnt++;
            total++; if (longint'(bus.ik) !== m_ik) $display("FAIL rand_ik[%0d] ek=%0d ki=%0d got %0d want %0d", i, e, k, bus.ik, m_ik); else pass_cnt++;
            total++; if (bus.sat !== m_sat) $display("FAIL rand_sat[%0d] got %0b want %0b", i, bus.sat, m_sat); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_clear_abort();
        test_operand_latch();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
